// File: rtl/slow_to_fast_pkg.sv
// Shared types and constants for the slow-domain synchronizer scheduler.
package slow_to_fast_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_ACK  = 2'd2
    } state_e;

    localparam int HOLD_CNT_W = 8;
    localparam int DEFAULT_S  = 12;

endpackage

// File: rtl/slow_to_fast_scheduler_rr_picker.sv
// Combinational round-robin picker: first set request above the last winner, wrapping.
module rr_picker #(
    parameter int N = 4
) (
    input  logic [N-1:0]         i_req,
    input  logic [$clog2(N)-1:0] i_last,
    output logic                 o_any,
    output logic [$clog2(N)-1:0] o_winner
);

    localparam int W = $clog2(N);

    logic [W-1:0] w_idx;
    logic         w_hit;

    // Scan N positions starting just above the last winner; the first hit wins.
    always_comb begin
        o_any    = 1'b0;
        o_winner = '0;
        w_idx    = '0;
        w_hit    = 1'b0;
        for (int k = 1; k <= N; k++) begin
            w_idx    = W'((int'(i_last) + k) % N);
            w_hit    = !o_any && i_req[w_idx];
            o_winner = w_hit ? w_idx : o_winner;
            o_any    = o_any | w_hit;
        end
    end

endmodule

// File: rtl/slow_to_fast_scheduler.sv
// Shares one slow_to_fast channel among N requesters: grant, hold the word stable, then ack.
module slow_to_fast_scheduler
    import slow_to_fast_pkg::*;
#(
    parameter int S    = DEFAULT_S,
    parameter int N    = 4,
    parameter int HOLD = 3
) (
    input  logic                 i_slow_clk,
    input  logic                 i_reset,
    input  logic [N-1:0]         i_req,
    input  logic [N*S-1:0]       i_req_data,
    output logic [N-1:0]         o_ack,
    output logic [S-1:0]         o_async_data,
    output logic                 o_async_toggle,
    output logic                 o_busy,
    output logic [$clog2(N)-1:0] o_sel
);

    localparam int W = $clog2(N);

    state_e                r_state;
    logic [HOLD_CNT_W-1:0] r_cnt;
    logic [W-1:0]          r_last;

    logic                  w_any;
    logic [W-1:0]          w_win;
    logic [S-1:0]          w_win_data;

    rr_picker #(.N(N)) u_picker (
        .i_req    (i_req),
        .i_last   (r_last),
        .o_any    (w_any),
        .o_winner (w_win)
    );

    assign w_win_data = i_req_data[int'(w_win)*S +: S];

    // Scheduler FSM with registered outputs; req_data is sampled only on the grant edge.
    always_ff @(posedge i_slow_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state        <= ST_IDLE;
            r_cnt          <= '0;
            r_last         <= W'(N - 1);
            o_ack          <= '0;
            o_async_data   <= '0;
            o_async_toggle <= 1'b0;
            o_busy         <= 1'b0;
            o_sel          <= '0;
        end else begin
            o_ack <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        o_sel          <= w_win;
                        r_last         <= w_win;
                        o_async_data   <= w_win_data;
                        o_async_toggle <= ~o_async_toggle;
                        r_cnt          <= HOLD_CNT_W'(HOLD - 1);
                        o_busy         <= 1'b1;
                        r_state        <= ST_HOLD;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_HOLD: begin
                    if (r_cnt == '0) begin
                        o_ack   <= N'(1) << o_sel;
                        r_state <= ST_ACK;
                    end else begin
                        r_cnt <= r_cnt - HOLD_CNT_W'(1);
                    end
                end
                ST_ACK: begin
                    o_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    o_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_slow_to_fast_scheduler.sv
// Scoreboard bench: stimulus pushes expected acks, a negedge monitor pops and compares.
module tb_slow_to_fast_scheduler;

    localparam int SW = 12;

    typedef struct {
        logic [3:0]    ack;
        logic [SW-1:0] data;
        logic          tog;
        int            gap;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [3:0]    req;
    logic [47:0]   req_data;
    logic [3:0]    ack;
    logic [SW-1:0] async_data;
    logic          tog;
    logic          busy;
    logic [1:0]    sel;

    logic [3:0]    req1;
    logic [47:0]   data1;
    logic [3:0]    ack1;
    logic [SW-1:0] data_out1;
    logic          tog1;
    logic          busy1;
    logic [1:0]    sel1;

    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    int            last_ack_cyc = 0;
    exp_t          exp_q[$];
    exp_t          mon_e;
    logic          exp_tog = 1'b0;

    logic [SW-1:0] wmem [4][16];
    int            whead [4] = '{default: 0};
    int            wcnt  [4] = '{default: 0};

    slow_to_fast_scheduler #(.S(12), .N(4), .HOLD(3)) dut (
        .i_slow_clk     (clk),
        .i_reset        (rst),
        .i_req          (req),
        .i_req_data     (req_data),
        .o_ack          (ack),
        .o_async_data   (async_data),
        .o_async_toggle (tog),
        .o_busy         (busy),
        .o_sel          (sel)
    );

    slow_to_fast_scheduler #(.S(12), .N(4), .HOLD(1)) dut1 (
        .i_slow_clk     (clk),
        .i_reset        (rst),
        .i_req          (req1),
        .i_req_data     (data1),
        .o_ack          (ack1),
        .o_async_data   (data_out1),
        .o_async_toggle (tog1),
        .o_busy         (busy1),
        .o_sel          (sel1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input int idx, input logic [SW-1:0] w, input int gap);
        exp_t e;
        exp_tog = ~exp_tog;
        e.ack   = 4'b0001 << idx;
        e.data  = w;
        e.tog   = exp_tog;
        e.gap   = gap;
        exp_q.push_back(e);
    endtask

    task automatic load(input int i, input logic [SW-1:0] w);
        wmem[i][whead[i] + wcnt[i]] = w;
        wcnt[i]++;
        if (wcnt[i] == 1) begin
            req_data[i*12 +: 12] = w;
            req[i] = 1'b1;
        end
    endtask

    // One slow cycle; requesters that saw ack at this edge move to their next word or drop req.
    task automatic step();
        logic [3:0] a;
        a = ack;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            if (a[i]) begin
                if (wcnt[i] > 0) begin
                    whead[i]++;
                    wcnt[i]--;
                end
                if (wcnt[i] > 0) req_data[i*12 +: 12] = wmem[i][whead[i]];
                else req[i] = 1'b0;
            end
        end
    endtask

    task automatic drain(input string name);
        for (int k = 0; k < 200 && exp_q.size() > 0; k++) step();
        chk({name, "_drain"}, exp_q.size(), 0);
        step();
        step();
    endtask

    // Monitor: every ack pulse must match the oldest expected grant.
    always @(negedge clk) begin
        if (!rst && ack != 4'b0000) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ack: got %b required none", ack);
            end else begin
                mon_e = exp_q.pop_front();
                chk("ack_vec", ack, mon_e.ack);
                chk("ack_data", async_data, mon_e.data);
                chk("ack_toggle", tog, mon_e.tog);
                if (mon_e.gap != 0) chk("ack_gap", cyc - last_ack_cyc, mon_e.gap);
                last_ack_cyc = cyc;
            end
        end
    end

    initial begin
        int c1;
        int nacks;
        rst = 1'b1; req = 4'b0000; req_data = '0; req1 = 4'b0000; data1 = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ack", ack, 4'b0000);
        chk("rst_data", async_data, 12'h000);
        chk("rst_toggle", tog, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_sel", sel, 2'd0);
        chk("rst_h1_data", data_out1, 12'h000);
        rst = 1'b0;

        // Single request on requester 2.
        load(2, 12'hA5C);
        push_exp(2, 12'hA5C, 0);
        step();
        chk("t1_data_c1", async_data, 12'hA5C);
        chk("t1_toggle_c1", tog, 1'b1);
        chk("t1_busy_c1", busy, 1'b1);
        chk("t1_sel_c1", sel, 2'd2);
        step();
        step();
        chk("t1_ack_c3", ack, 4'b0000);
        chk("t1_busy_c3", busy, 1'b1);
        step();
        chk("t1_ack_c4", ack, 4'b0100);
        chk("t1_busy_c4", busy, 1'b1);
        step();
        chk("t1_ack_c5", ack, 4'b0000);
        chk("t1_busy_c5", busy, 1'b0);
        chk("t1_data_c5", async_data, 12'hA5C);
        step();

        // All four requesting from reset release.
        rst = 1'b1;
        exp_tog = 1'b0;
        for (int i = 0; i < 4; i++) begin
            load(i, SW'(i + 1));
            push_exp(i, SW'(i + 1), (i == 0) ? 0 : 5);
        end
        step();
        step();
        rst = 1'b0;
        drain("t2");

        // Fairness between requesters 1 and 3.
        for (int k = 0; k < 10; k++) begin
            load(1, SW'(12'h110 + k));
            load(3, SW'(12'h310 + k));
        end
        for (int j = 0; j < 20; j++) begin
            if (j % 2 == 0) push_exp(1, SW'(12'h110 + j / 2), (j == 0) ? 0 : 5);
            else            push_exp(3, SW'(12'h310 + j / 2), 5);
        end
        drain("fair");

        // Reset in the second HOLD cycle, then re-grant from requester 0 priority.
        load(2, 12'h777);
        load(3, 12'h888);
        step();
        chk("rst_pre_data", async_data, 12'h777);
        step();
        rst = 1'b1;
        #1;
        chk("rst_mid_ack", ack, 4'b0000);
        chk("rst_mid_busy", busy, 1'b0);
        chk("rst_mid_data", async_data, 12'h000);
        chk("rst_mid_toggle", tog, 1'b0);
        exp_tog = 1'b0;
        push_exp(2, 12'h777, 0);
        push_exp(3, 12'h888, 5);
        step();
        step();
        rst = 1'b0;
        drain("rst_regrant");

        // Protocol violation: req dropped and data changed mid-HOLD.
        load(0, 12'h0AB);
        push_exp(0, 12'h0AB, 0);
        step();
        step();
        req[0] = 1'b0;
        req_data[11:0] = 12'hFFF;
        wcnt[0] = 0;
        step();
        chk("viol_data_c3", async_data, 12'h0AB);
        step();
        chk("viol_ack_c4", ack, 4'b0001);
        chk("viol_data_c4", async_data, 12'h0AB);
        drain("viol");
        repeat (10) step();

        // HOLD=1 instance: back-to-back words from one requester.
        c1 = 0;
        nacks = 0;
        req1 = 4'b0001;
        data1[11:0] = 12'h101;
        for (int k = 0; k < 15 && nacks < 3; k++) begin
            @(posedge clk);
            #1;
            c1++;
            if (ack1 != 4'b0000) begin
                chk("h1_ack_vec", ack1, 4'b0001);
                chk("h1_ack_cycle", c1, 2 + 3 * nacks);
                chk("h1_data", data_out1, 12'h101 + nacks);
                nacks++;
                if (nacks < 3) data1[11:0] = SW'(12'h101 + nacks);
                else req1 = 4'b0000;
            end
        end
        chk("h1_ack_count", nacks, 3);
        repeat (4) @(posedge clk);
        #1;
        chk("h1_busy_end", busy1, 1'b0);

        chk("final_queue", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
